// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with a fixed, programmable response latency.
// Define DMEM_RESP_ERR_EN to add dmem_err_o and return 32'hDEADBEEF on out-of-range loads.
//
// state     | meaning
// RSP_IDLE  | waiting for dmem_req_i; captures the request when it is seen
// RSP_WAIT  | latency countdown; inputs ignored
// RSP_DONE  | dmem_valid_o pulse; store/load took effect on the edge entering here
// RSP_HOLD  | waits for dmem_req_i to drop so a still-high request is not re-served
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  localparam int ADDR_WIDTH = 32,
  localparam int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_be_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_valid_o,
`ifdef DMEM_RESP_ERR_EN
  output logic                  dmem_err_o,
`endif
  output logic                  busy_o
);

  localparam logic [1:0] RSP_IDLE = 2'd0;
  localparam logic [1:0] RSP_WAIT = 2'd1;
  localparam logic [1:0] RSP_DONE = 2'd2;
  localparam logic [1:0] RSP_HOLD = 2'd3;

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  oor_q, oor_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  enter_done;
  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [3:0]            op_be;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      op_idx;
  logic                  in_range;

`ifdef DMEM_RESP_ERR_EN
  localparam logic [DATA_WIDTH-1:0] OOR_RDATA = 32'hDEADBEEF;
  assign dmem_err_o = (state_q == RSP_DONE) && oor_q;
`else
  localparam logic [DATA_WIDTH-1:0] OOR_RDATA = 32'h0;
  logic unused_oor;
  assign unused_oor = oor_q;
`endif

  // With LATENCY=1 the access completes straight out of IDLE, so use the live inputs there.
  assign op_we    = (state_q == RSP_IDLE) ? dmem_we_i    : we_q;
  assign op_addr  = (state_q == RSP_IDLE) ? dmem_addr_i  : addr_q;
  assign op_wdata = (state_q == RSP_IDLE) ? dmem_wdata_i : wdata_q;
  assign op_be    = (state_q == RSP_IDLE) ? dmem_be_i    : be_q;

  assign offset   = op_addr - BASE_ADDR;
  assign op_idx   = offset[IDX_W+1:2];
  assign in_range = ({1'b0, op_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, op_addr} < ADDR_LIMIT);

  logic unused_offset;
  assign unused_offset = ^{offset[ADDR_WIDTH-1:IDX_W+2], offset[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    enter_done = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (dmem_req_i) begin
          we_d    = dmem_we_i;
          addr_d  = dmem_addr_i;
          wdata_d = dmem_wdata_i;
          be_d    = dmem_be_i;
          if (LATENCY == 1) begin
            state_d    = RSP_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = RSP_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      RSP_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = RSP_DONE;
          enter_done = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP_DONE: state_d = RSP_HOLD;
      RSP_HOLD: if (!dmem_req_i) state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

  always_comb begin
    oor_d   = oor_q;
    rdata_d = rdata_q;
    if (enter_done) begin
      oor_d = !in_range;
      if (!op_we) rdata_d = in_range ? mem_q[op_idx] : OOR_RDATA;
    end
  end

  // The array is deliberately left out of the reset branch: reset only abandons the access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      if (enter_done && op_we && in_range) begin
        for (int i = 0; i < 4; i++) begin
          if (op_be[i]) mem_q[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dmem_rdata_o = rdata_q;
  assign dmem_valid_o = (state_q == RSP_DONE);
  assign busy_o       = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1 and 15) checked every cycle
// against a cycle-count/array model, plus directed transfers with literal expectations.
module tb_dmem_responder;

  localparam int          NDUT = 3;
  localparam int          LAT [NDUT] = '{2, 1, 15};
  localparam int          DEP [NDUT] = '{1024, 1024, 16};
  localparam logic [31:0] BAS [NDUT] = '{32'h0, 32'h0, 32'h100};
`ifdef DMEM_RESP_ERR_EN
  localparam logic [31:0] OOR_RD = 32'hDEADBEEF;
`else
  localparam logic [31:0] OOR_RD = 32'h0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req   [NDUT];
  logic        we    [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic [3:0]  be    [NDUT];
  logic [31:0] rdata [NDUT];
  logic        valid [NDUT];
  logic        busy  [NDUT];
`ifdef DMEM_RESP_ERR_EN
  logic        err   [NDUT];
`endif

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEP[g]),
      .LATENCY    (LAT[g]),
      .BASE_ADDR  (BAS[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .dmem_req_i  (req[g]),
      .dmem_we_i   (we[g]),
      .dmem_addr_i (addr[g]),
      .dmem_wdata_i(wdata[g]),
      .dmem_be_i   (be[g]),
      .dmem_rdata_o(rdata[g]),
      .dmem_valid_o(valid[g]),
`ifdef DMEM_RESP_ERR_EN
      .dmem_err_o  (err[g]),
`endif
      .busy_o      (busy[g])
    );
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint      cyc = 0;
  bit          m_busy [NDUT];
  longint      m_acc  [NDUT];
  logic        m_we   [NDUT];
  logic [31:0] m_addr [NDUT];
  logic [31:0] m_wd   [NDUT];
  logic [3:0]  m_be   [NDUT];
  logic [31:0] m_rd   [NDUT];
  logic [31:0] m_mem  [NDUT][1024];

  function automatic bit in_map(input int d, input logic [31:0] a);
    longint ua = longint'(a);
    longint lo = longint'(BAS[d]);
    return (ua >= lo) && (ua < lo + 4 * longint'(DEP[d]));
  endfunction

  function automatic int widx(input int d, input logic [31:0] a);
    logic [31:0] off = a - BAS[d];
    return int'(off >> 2);
  endfunction

  // Request seen at edge A completes at edge A+LAT-1 (valid visible until edge A+LAT);
  // the responder is free again at the first edge after A+LAT where req is low.
  initial begin
    for (int d = 0; d < NDUT; d++) m_busy[d] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
        if (!rst_n) begin
          m_busy[d] = 0;
          m_rd[d]   = 32'h0;
        end else begin
          if (!m_busy[d]) begin
            if (req[d]) begin
              m_busy[d] = 1;
              m_acc[d]  = cyc;
              m_we[d]   = we[d];
              m_addr[d] = addr[d];
              m_wd[d]   = wdata[d];
              m_be[d]   = be[d];
            end
          end else if (cyc > m_acc[d] + LAT[d] && !req[d]) begin
            m_busy[d] = 0;
          end
          if (m_busy[d] && cyc == m_acc[d] + LAT[d] - 1) begin
            if (m_we[d]) begin
              if (in_map(d, m_addr[d]))
                for (int i = 0; i < 4; i++)
                  if (m_be[d][i]) m_mem[d][widx(d, m_addr[d])][8*i +: 8] = m_wd[d][8*i +: 8];
            end else begin
              m_rd[d] = in_map(d, m_addr[d]) ? m_mem[d][widx(d, m_addr[d])] : OOR_RD;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int d = 0; d < NDUT; d++) begin
          logic        ev, eb;
          logic [31:0] er;
          ev = rst_n && m_busy[d] && (cyc == m_acc[d] + LAT[d] - 1);
          eb = rst_n && m_busy[d];
          er = rst_n ? m_rd[d] : 32'h0;
          chk1($sformatf("valid[%0d]", d), valid[d], ev);
          chk1($sformatf("busy[%0d]", d), busy[d], eb);
          chk32($sformatf("rdata[%0d]", d), rdata[d], er);
`ifdef DMEM_RESP_ERR_EN
          chk1($sformatf("err[%0d]", d), err[d], ev && !in_map(d, m_addr[d]));
`endif
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input int exp_lat, input int extra, input bit early,
                      output logic [31:0] rd);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (busy[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy[d]) chk1("idle_wait", busy[d], 1'b0);
    we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b; req[d] = 1'b1;
    lat = 0; rd = 32'h0; n = 0;
    while (lat == 0 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid[d]) begin
        lat = n;
        rd  = rdata[d];
      end else if (early && n == 1) begin
        req[d] = 1'b0;
      end
    end
    chk32($sformatf("latency[%0d]", d), 32'(lat), 32'(exp_lat));
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      chk1("hold_no_valid", valid[d], 1'b0);
      chk1("hold_busy", busy[d], 1'b1);
    end
    req[d] = 1'b0;
    n = 0;
    while (busy[d] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1("release", busy[d], 1'b0);
  endtask

  task automatic st(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                    input int exp_lat, input bit early);
    logic [31:0] rd;
    xfer(d, 1'b1, a, wd, b, exp_lat, 0, early, rd);
  endtask

  task automatic ld(input int d, input logic [31:0] a, input logic [31:0] exp, input int exp_lat,
                    input int extra, input bit early, input string nm);
    logic [31:0] rd;
    xfer(d, 1'b0, a, 32'h0, 4'hF, exp_lat, extra, early, rd);
    chk32(nm, rd, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
    end
    #1 rst_n = 1'b0;
    started = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_valid", valid[0], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);
    chk32("rst_rdata", rdata[0], 32'h0);
    rst_n = 1'b1;

    // basic store/load, address LSBs ignored
    st(0, 32'h10, 32'hCAFEBABE, 4'hF, 2, 0);
    ld(0, 32'h10, 32'hCAFEBABE, 2, 0, 0, "t1_load");
    ld(0, 32'h13, 32'hCAFEBABE, 2, 0, 0, "t1_addr_lsb");

    // byte enables
    st(0, 32'h20, 32'h11223344, 4'hF, 2, 0);
    st(0, 32'h20, 32'hAABBCCDD, 4'b0100, 2, 0);
    ld(0, 32'h20, 32'h11BB3344, 2, 0, 0, "t2_be0100");
    st(0, 32'h24, 32'h11223344, 4'hF, 2, 0);
    st(0, 32'h24, 32'hAABBCCDD, 4'b0101, 2, 0);
    ld(0, 32'h24, 32'h11BB33DD, 2, 0, 0, "t2_be0101");
    st(0, 32'h10, 32'hFFFFFFFF, 4'b0000, 2, 0);
    ld(0, 32'h10, 32'hCAFEBABE, 2, 0, 0, "t2_be0000");

    // handshake: long hold, read-after-write, early request drop
    ld(0, 32'h10, 32'hCAFEBABE, 2, 3, 0, "t3_hold");
    st(0, 32'h30, 32'h0BADF00D, 4'hF, 2, 0);
    ld(0, 32'h30, 32'h0BADF00D, 2, 0, 0, "t3_raw");
    st(0, 32'h34, 32'h5A5A5A5A, 4'hF, 2, 1);
    ld(0, 32'h34, 32'h5A5A5A5A, 2, 0, 1, "t3_early");

    // out of range and map edges
    st(0, 32'h0, 32'h01020304, 4'hF, 2, 0);
    ld(0, 32'h1000, OOR_RD, 2, 0, 0, "t5_oor_load");
    st(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 2, 0);
    ld(0, 32'h0, 32'h01020304, 2, 0, 0, "t5_word0");
    st(0, 32'hFFC, 32'h76543210, 4'hF, 2, 0);
    ld(0, 32'hFFC, 32'h76543210, 2, 0, 0, "t5_last");
    ld(0, 32'hFFFFFFFC, OOR_RD, 2, 0, 0, "t5_top");

    // LATENCY=1
    st(1, 32'h8, 32'hA5A50001, 4'hF, 1, 0);
    ld(1, 32'h8, 32'hA5A50001, 1, 0, 0, "t4_l1");
    ld(1, 32'h8, 32'hA5A50001, 1, 3, 0, "t4_l1_hold");

    // LATENCY=15, BASE_ADDR=0x100, 16 words
    st(2, 32'h100, 32'h600DF00D, 4'hF, 15, 0);
    ld(2, 32'h100, 32'h600DF00D, 15, 0, 0, "t4_l15");
    st(2, 32'h13C, 32'h13C13C13, 4'hF, 15, 0);
    ld(2, 32'h13C, 32'h13C13C13, 15, 0, 0, "t4_l15_last");
    ld(2, 32'hFC, OOR_RD, 15, 0, 0, "t5_below_base");
    ld(2, 32'h140, OOR_RD, 15, 0, 0, "t5_l15_oor");
    st(2, 32'h140, 32'hFFFFFFFF, 4'hF, 15, 0);
    ld(2, 32'h100, 32'h600DF00D, 15, 0, 0, "t5_l15_word0");

    // reset while a store is waiting
    st(0, 32'h40, 32'h5, 4'hF, 2, 0);
    ld(0, 32'h30, 32'h0BADF00D, 2, 0, 0, "t6_preload");
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; be[0] = 4'hF; req[0] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk1("t6_rst_valid", valid[0], 1'b0);
    chk1("t6_rst_busy", busy[0], 1'b0);
    chk32("t6_rst_rdata", rdata[0], 32'h0);
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    chk1("t6_rst_valid2", valid[0], 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ld(0, 32'h40, 32'h5, 2, 0, 0, "t6_after_rst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
